result_collector: RTL and testbench

- Writer-side counterpart of the result display path.
- Accepts a serial stream of signed results from the compute core over a valid/ready handshake and saturates each to 0..255.
- Writes the results, in fixed order, into the eight 8-bit result registers that the display consumes.
- Flags completion and overflow so top-level control can start display sequencing.

---
 rtl/result_pkg.sv | 25 ++
 rtl/result_saturator.sv | 22 ++
 rtl/result_collector.sv | 111 +++++++++++
 tb/tb_result_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared encodings and limits for the result collector: FSM states,
// slot indices in display order and the saturation bounds.
package result_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned N_SLOTS = 8;

  localparam int unsigned SLOT_C9_11 = 0;
  localparam int unsigned SLOT_C9_12 = 1;
  localparam int unsigned SLOT_C9_21 = 2;
  localparam int unsigned SLOT_C9_22 = 3;
  localparam int unsigned SLOT_C4_11 = 4;
  localparam int unsigned SLOT_C4_12 = 5;
  localparam int unsigned SLOT_C4_21 = 6;
  localparam int unsigned SLOT_C4_22 = 7;

  localparam logic [7:0] SAT_MIN = 8'd0;
  localparam logic [7:0] SAT_MAX = 8'd255;

endpackage

// File: rtl/result_saturator.sv
// Clamps a signed two's-complement sample into the unsigned 0..255 range
// used by the display result registers.
module result_saturator
  import result_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic [IN_W-1:0] in_data,
  output logic [7:0]      sat_data
);

  // Sign bit means negative; any set bit between the sign and bit 8 means > 255.
  always_comb begin
    sat_data = in_data[7:0];
    if (in_data[IN_W-1]) begin
      sat_data = SAT_MIN;
    end else if (|in_data[IN_W-2:8]) begin
      sat_data = SAT_MAX;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects eight saturated results over a valid/ready stream into the fixed
// display register bank and reports completion and overflow.
module result_collector
  import result_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic            clk_1hz,
  input  logic            resetn,
  input  logic            start,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic [7:0]      c9_11,
  output logic [7:0]      c9_12,
  output logic [7:0]      c9_21,
  output logic [7:0]      c9_22,
  output logic [7:0]      c4_11,
  output logic [7:0]      c4_12,
  output logic [7:0]      c4_21,
  output logic [7:0]      c4_22,
  output logic [3:0]      count,
  output logic            done,
  output logic            err
);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] slot_q [N_SLOTS];
  logic [7:0] sat_data;
  logic       clear_load;
  logic       write_slot;
  logic       set_err;

  result_saturator #(.IN_W(IN_W)) u_sat (
    .in_data (in_data),
    .sat_data(sat_data)
  );

  // start always wins over a concurrent sample or overflow flag.
  always_comb begin
    state_d    = state_q;
    clear_load = 1'b0;
    write_slot = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_load = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (start) begin
          clear_load = 1'b1;
        end else if (in_valid) begin
          write_slot = 1'b1;
          if (count == 4'(N_SLOTS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          clear_load = 1'b1;
          state_d    = ST_LOAD;
        end else if (in_valid) begin
          set_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1hz or posedge resetn) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_load) begin
        for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (write_slot) begin
          slot_q[count[2:0]] <= sat_data;
          count              <= count + 4'd1;
        end
        if (set_err) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);

  assign c9_11 = slot_q[SLOT_C9_11];
  assign c9_12 = slot_q[SLOT_C9_12];
  assign c9_21 = slot_q[SLOT_C9_21];
  assign c9_22 = slot_q[SLOT_C9_22];
  assign c4_11 = slot_q[SLOT_C4_11];
  assign c4_12 = slot_q[SLOT_C4_12];
  assign c4_21 = slot_q[SLOT_C4_21];
  assign c4_22 = slot_q[SLOT_C4_22];

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus pushes expected register
// snapshots from a queue-based reference model, a monitor pops and compares.
module tb_result_collector;

  typedef struct packed {
    logic [7:0][7:0] slots;
    logic [3:0]      count;
    logic            done;
    logic            err;
    logic            ready;
  } snap_t;

  logic        clk_1hz = 1'b0;
  logic        resetn  = 1'b1;
  logic        start   = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready;
  logic [7:0]  c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22;
  logic [3:0]  count;
  logic        done;
  logic        err;
  logic [7:0]  dut_slots [8];

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a load has ever been started, the list of
  // accepted saturated samples, and the sticky overflow flag.
  bit         m_active = 1'b0;
  logic [7:0] m_accepted [$];
  bit         m_err = 1'b0;
  snap_t      exp_q [$];

  result_collector #(.IN_W(12)) dut (
    .clk_1hz (clk_1hz),
    .resetn  (resetn),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .c9_11   (c9_11),
    .c9_12   (c9_12),
    .c9_21   (c9_21),
    .c9_22   (c9_22),
    .c4_11   (c4_11),
    .c4_12   (c4_12),
    .c4_21   (c4_21),
    .c4_22   (c4_22),
    .count   (count),
    .done    (done),
    .err     (err)
  );

  always #5 clk_1hz = ~clk_1hz;

  assign dut_slots[0] = c9_11;
  assign dut_slots[1] = c9_12;
  assign dut_slots[2] = c9_21;
  assign dut_slots[3] = c9_22;
  assign dut_slots[4] = c4_11;
  assign dut_slots[5] = c4_12;
  assign dut_slots[6] = c4_21;
  assign dut_slots[7] = c4_22;

  function automatic logic [7:0] satRef(input logic [11:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic snap_t modelSnapshot();
    snap_t s;
    for (int i = 0; i < 8; i++) begin
      s.slots[i] = (i < m_accepted.size()) ? m_accepted[i] : 8'd0;
    end
    s.count = 4'(m_accepted.size());
    s.done  = m_active && (m_accepted.size() == 8);
    s.ready = m_active && (m_accepted.size() < 8);
    s.err   = m_err;
    return s;
  endfunction

  function automatic void modelEdge(input logic s, input logic v, input logic [11:0] d);
    if (s) begin
      m_active = 1'b1;
      m_accepted.delete();
      m_err = 1'b0;
    end else if (m_active && v) begin
      if (m_accepted.size() < 8) m_accepted.push_back(satRef(d));
      else m_err = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [11:0] d);
    @(negedge clk_1hz);
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk_1hz);
    modelEdge(s, v, d);
    exp_q.push_back(modelSnapshot());
  endtask

  task automatic applyReset();
    @(negedge clk_1hz);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'($urandom_range(0, 4095));
    #1 resetn = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) checkOutput($sformatf("reset_slot%0d", i), int'(dut_slots[i]), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_ready", int'(in_ready), 0);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    #1 resetn = 1'b0;
    m_active = 1'b0;
    m_accepted.delete();
    m_err = 1'b0;
    @(posedge clk_1hz);
    modelEdge(1'b0, 1'b0, 12'd0);
    exp_q.push_back(modelSnapshot());
  endtask

  // Monitor: every falling edge the registered outputs are compared with the
  // snapshot expected after the preceding rising edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk_1hz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
          checkOutput($sformatf("slot%0d", i), int'(dut_slots[i]), int'(e.slots[i]));
        end
        checkOutput("count", int'(count), int'(e.count));
        checkOutput("done", int'(done), int'(e.done));
        checkOutput("err", int'(err), int'(e.err));
        checkOutput("in_ready", int'(in_ready), int'(e.ready));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] sat_vec [8];
    int accepted;
    int idx;

    applyReset();

    $display("[TB] full load 10..80");
    applyStimulus(1'b1, 1'b0, 12'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 12'(i * 10));
    applyStimulus(1'b0, 1'b0, 12'd0);

    $display("[TB] saturation load");
    sat_vec[0] = 12'hFFB; sat_vec[1] = 12'd0;   sat_vec[2] = 12'd255; sat_vec[3] = 12'd256;
    sat_vec[4] = 12'h7FF; sat_vec[5] = 12'h800; sat_vec[6] = 12'd128; sat_vec[7] = 12'd1;
    applyStimulus(1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, sat_vec[i]);

    $display("[TB] overflow after done");
    applyStimulus(1'b0, 1'b1, 12'd99);
    applyStimulus(1'b0, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b1, 12'd99);
    applyStimulus(1'b1, 1'b1, 12'd99);

    $display("[TB] backpressure gaps");
    accepted = 0;
    idx = 0;
    while (accepted < 8) begin
      if (idx % 3 == 0) begin
        applyStimulus(1'b0, 1'b1, 12'($urandom_range(0, 4095)));
        accepted++;
      end else begin
        applyStimulus(1'b0, 1'b0, 12'($urandom_range(0, 4095)));
      end
      idx++;
    end

    $display("[TB] restart mid-load");
    applyStimulus(1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 12'($urandom_range(0, 300)));
    applyStimulus(1'b1, 1'b1, 12'd7);
    applyStimulus(1'b0, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b1, 12'd42);

    $display("[TB] reset mid-load");
    applyStimulus(1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 12'($urandom_range(1, 255)));
    applyReset();
    applyStimulus(1'b0, 1'b1, 12'd33);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    12'($urandom_range(0, 4095)));
    end

    @(negedge clk_1hz);
    @(negedge clk_1hz);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
